// File: rtl/reg_writeback_ctrl_if.sv
// Producer-side writeback request bundle: memory-load and ALU result channels,
// each a valid/ready handshake carrying a destination register and its data.
interface reg_writeback_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;

  modport master (
    output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
    input  mem_ready, alu_ready
  );

  modport slave (
    input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
    output mem_ready, alu_ready
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Owns the register file write port: in-order FIFO of load/ALU writebacks, one retire per cycle.
// Define WB_BYPASS_EN to add the lookup_* combinational search over in-flight writes.
module reg_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int CW    = 3
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  reg_writeback_ctrl_if.slave  wb,
  input  logic                 wb_stall,
  output logic                 reg_write,
  output logic [AW-1:0]        A3,
  output logic [DW-1:0]        WD3,
  output logic [CW-1:0]        count,
  output logic                 pending
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0]        lookup_addr,
  output logic                 lookup_hit,
  output logic [DW-1:0]        lookup_data
`endif
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  wb_req_t       fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          not_full, push_hs, push, pop;
  wb_req_t       push_req;

  // Ready depends only on occupancy, so a full FIFO never passes a request
  // through in the same cycle it pops.
  assign not_full     = (count < CW'(DEPTH));
  assign wb.mem_ready = not_full;
  assign wb.alu_ready = not_full && !wb.mem_valid;
  assign push_hs      = (wb.mem_valid && wb.mem_ready) || (wb.alu_valid && wb.alu_ready);

  always_comb begin
    push_req = '0;
    if (wb.mem_valid) begin
      push_req.addr = wb.mem_addr;
      push_req.data = wb.mem_data;
    end else begin
      push_req.addr = wb.alu_addr;
      push_req.data = wb.alu_data;
    end
  end

  // Register-0 writes complete the handshake but are silently dropped.
  assign push    = push_hs && (push_req.addr != '0);
  assign pop     = (count != '0) && !wb_stall;
  assign pending = (count != '0) || reg_write;

  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr] <= push_req;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      reg_write <= 1'b0;
      A3        <= '0;
      WD3       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        reg_write <= 1'b1;
        A3        <= fifo_q[rd_ptr].addr;
        WD3       <= fifo_q[rd_ptr].data;
      end else begin
        reg_write <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  logic [PW-1:0] lk_idx;

  // Scan oldest to youngest so later (younger) matches override; output stage is lowest priority.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_idx      = '0;
    if (reg_write && (A3 == lookup_addr)) begin
      lookup_hit  = 1'b1;
      lookup_data = WD3;
    end
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (fifo_q[lk_idx].addr == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = fifo_q[lk_idx].data;
      end
    end
    if (lookup_addr == '0) begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
    end
  end
`endif
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: vector table plus scoreboard of expected retirements.
module tb_reg_writeback_ctrl;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        wb_stall;
  logic        reg_write;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [2:0]  count;
  logic        pending;
`ifdef WB_BYPASS_EN
  logic [4:0]  lookup_addr;
  logic        lookup_hit;
  logic [31:0] lookup_data;
`endif

  reg_writeback_ctrl_if #(.AW(5), .DW(32)) wb ();

  reg_writeback_ctrl #(.DEPTH(4), .AW(5), .DW(32), .CW(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .wb(wb), .wb_stall(wb_stall),
    .reg_write(reg_write), .A3(A3), .WD3(WD3), .count(count), .pending(pending)
`ifdef WB_BYPASS_EN
    , .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [4:0] addr; logic [31:0] data; } wb_exp_t;
  typedef struct { logic is_mem; logic [4:0] addr; logic [31:0] data; logic exp_wr; } vec_t;

  wb_exp_t exp_q[$];
  wb_exp_t mon_e;
  vec_t    vec[12];
  int      n_cmp = 0;
  int      n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write seen on the port must match the oldest expected entry.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wb_unexpected: A3=%0d WD3=%0h, required no write", A3, WD3);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_A3", 64'(A3), 64'(mon_e.addr));
        chk("wb_WD3", 64'(WD3), 64'(mon_e.data));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic is_mem, input logic [4:0] a, input logic [31:0] d, input logic exp_wr);
    int   t = 0;
    logic acc = 1'b0;
    if (is_mem) begin
      wb.mem_valid = 1'b1; wb.mem_addr = a; wb.mem_data = d;
    end else begin
      wb.alu_valid = 1'b1; wb.alu_addr = a; wb.alu_data = d;
    end
    while (!acc && t < 20) begin
      @(negedge CLK);
      acc = is_mem ? wb.mem_ready : wb.alu_ready;
      @(posedge CLK);
      t++;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: addr %0d not accepted in 20 cycles, required acceptance", a);
    end else if (exp_wr) begin
      exp_q.push_back('{a, d});
    end
    #1;
    wb.mem_valid = 1'b0;
    wb.alu_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{1'b1, 5'd10, 32'h1000_0010, 1'b1};
    vec[1]  = '{1'b0, 5'd11, 32'h1000_0011, 1'b1};
    vec[2]  = '{1'b1, 5'd12, 32'h1000_0012, 1'b1};
    vec[3]  = '{1'b0, 5'd13, 32'h1000_0013, 1'b1};
    vec[4]  = '{1'b0, 5'd14, 32'h2000_0014, 1'b1};
    vec[5]  = '{1'b1, 5'd15, 32'h2000_0015, 1'b1};
    vec[6]  = '{1'b0, 5'd16, 32'h2000_0016, 1'b1};
    vec[7]  = '{1'b1, 5'd17, 32'h2000_0017, 1'b1};
    vec[8]  = '{1'b0, 5'd20, 32'h0000_AAAA, 1'b1};
    vec[9]  = '{1'b1, 5'd20, 32'h0000_BBBB, 1'b1};
    vec[10] = '{1'b0, 5'd0,  32'hFFFF_FFFF, 1'b0};
    vec[11] = '{1'b1, 5'd31, 32'h3131_3131, 1'b1};

    RST_N = 1'b0; wb_stall = 1'b0;
    wb.mem_valid = 1'b0; wb.mem_addr = '0; wb.mem_data = '0;
    wb.alu_valid = 1'b0; wb.alu_addr = '0; wb.alu_data = '0;
`ifdef WB_BYPASS_EN
    lookup_addr = '0;
`endif
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_A3", 64'(A3), 64'd0);
    chk("rst_WD3", 64'(WD3), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_mem_ready", 64'(wb.mem_ready), 64'd1);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Asynchronous reset mid-stream: 3 queued, one in the output stage.
    wb_stall = 1'b1;
    send(1'b1, 5'd1, 32'h0101, 1'b1);
    send(1'b0, 5'd2, 32'h0202, 1'b1);
    send(1'b1, 5'd3, 32'h0303, 1'b1);
    send(1'b0, 5'd6, 32'h0606, 1'b1);
    wb_stall = 1'b0;
    @(posedge CLK); #1;
    wb_stall = 1'b1;
    chk("midrst_pre_reg_write", 64'(reg_write), 64'd1);
    chk("midrst_pre_count", 64'(count), 64'd3);
    RST_N = 1'b0;
    #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_reg_write", 64'(reg_write), 64'd0);
    chk("midrst_A3", 64'(A3), 64'd0);
    chk("midrst_WD3", 64'(WD3), 64'd0);
    exp_q.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    wb_stall = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    chk("postrst_count", 64'(count), 64'd0);
    chk("postrst_pending", 64'(pending), 64'd0);

    // Single ALU write latency.
    send(1'b0, 5'd5, 32'hDEAD_BEEF, 1'b1);
    chk("lat_edge1_reg_write", 64'(reg_write), 64'd0);
    chk("lat_edge1_count", 64'(count), 64'd1);
    @(posedge CLK); #1;
    chk("lat_edge2_reg_write", 64'(reg_write), 64'd1);
    chk("lat_edge2_A3", 64'(A3), 64'd5);
    chk("lat_edge2_WD3", 64'(WD3), 64'hDEAD_BEEF);
    @(posedge CLK); #1;
    chk("lat_edge3_reg_write", 64'(reg_write), 64'd0);
    chk("lat_edge3_pending", 64'(pending), 64'd0);

    // Load has priority over a simultaneous ALU request.
    wb.mem_valid = 1'b1; wb.mem_addr = 5'd3; wb.mem_data = 32'h11;
    wb.alu_valid = 1'b1; wb.alu_addr = 5'd4; wb.alu_data = 32'h22;
    @(negedge CLK);
    chk("arb_mem_ready", 64'(wb.mem_ready), 64'd1);
    chk("arb_alu_ready", 64'(wb.alu_ready), 64'd0);
    @(posedge CLK);
    exp_q.push_back('{5'd3, 32'h11});
    #1;
    wb.mem_valid = 1'b0;
    @(negedge CLK);
    chk("arb_alu_ready_next", 64'(wb.alu_ready), 64'd1);
    @(posedge CLK);
    exp_q.push_back('{5'd4, 32'h22});
    #1;
    wb.alu_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;

    // Fill under stall, then drain four back-to-back writes.
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) send(vec[i].is_mem, vec[i].addr, vec[i].data, vec[i].exp_wr);
    chk("full_count", 64'(count), 64'd4);
    chk("full_mem_ready", 64'(wb.mem_ready), 64'd0);
    chk("full_alu_ready", 64'(wb.alu_ready), 64'd0);
    wb_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("drain_reg_write_%0d", k), 64'(reg_write), 64'd1);
    end
    @(posedge CLK); #1;
    chk("drain_done_reg_write", 64'(reg_write), 64'd0);
    chk("drain_done_count", 64'(count), 64'd0);

    // Second fill exercises pointer wrap; full FIFO must not pass through while popping.
    wb_stall = 1'b1;
    for (int i = 4; i < 8; i++) send(vec[i].is_mem, vec[i].addr, vec[i].data, vec[i].exp_wr);
    wb.mem_valid = 1'b1; wb.mem_addr = 5'd9; wb.mem_data = 32'h99;
    wb_stall = 1'b0;
    @(negedge CLK);
    chk("full_pop_no_passthru", 64'(wb.mem_ready), 64'd0);
    send(1'b1, 5'd9, 32'h99, 1'b1);
    repeat (6) @(posedge CLK);
    #1;

    // Streaming with duplicate addresses and a register-0 request.
    for (int i = 8; i < 12; i++) send(vec[i].is_mem, vec[i].addr, vec[i].data, vec[i].exp_wr);
    repeat (6) @(posedge CLK);
    #1;

    // Register-0 write is accepted and dropped.
    wb.alu_valid = 1'b1; wb.alu_addr = 5'd0; wb.alu_data = 32'hFFFF_FFFF;
    @(negedge CLK);
    chk("r0_alu_ready", 64'(wb.alu_ready), 64'd1);
    @(posedge CLK); #1;
    wb.alu_valid = 1'b0;
    chk("r0_count", 64'(count), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("r0_no_write_%0d", k), 64'(reg_write), 64'd0);
    end
    @(posedge CLK); #1;

`ifdef WB_BYPASS_EN
    wb_stall = 1'b1;
    send(1'b0, 5'd7, 32'hA, 1'b1);
    send(1'b1, 5'd7, 32'hB, 1'b1);
    lookup_addr = 5'd7;
    #1;
    chk("byp_hit7", 64'(lookup_hit), 64'd1);
    chk("byp_data7", 64'(lookup_data), 64'hB);
    lookup_addr = 5'd8;
    #1;
    chk("byp_hit8", 64'(lookup_hit), 64'd0);
    chk("byp_data8", 64'(lookup_data), 64'd0);
    lookup_addr = 5'd0;
    #1;
    chk("byp_hit0", 64'(lookup_hit), 64'd0);
    @(posedge CLK); #1;
    wb_stall = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
`endif

    repeat (4) @(posedge CLK);
    #1;
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("final_count", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
